matrix_scan_scheduler: RTL and testbench
========================================

Name: matrix_scan_scheduler

Overview:
- Synchronous scan scheduler for the LED matrix and 7-segment display.
- Replaces the ripple-clock row and image selectors with clock-enable timing in the single `clock` domain.
- Sequences row scanning with anti-ghosting blanking, applies image changes only at frame boundaries through a valid/ready handshake, and generates a blink phase and a digit-multiplex select.
- Sits between the irrigation control FSM (the image requester) and the matrix/display pin drivers.

Parameters:
- ROW_DIV, 65536: clock cycles per row slot (about 763 Hz at 50 MHz); must be greater than BLANK_CYC+2.
- BLANK_CYC, 64: cycles per slot with row_en low, at the start of the slot.
- ROWS, 7: rows per frame; range 2..8.
- BLINK_FRAMES, 64: frames per blink half-period.
- DIGIT_DIV, 65536: cycles per digit slot.
- DIGITS, 4: display digits; range 2..4.

Ports:
- clock  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high
- enable  in  1  scanning on
- blink  in  1  blink the matrix image
- image_req  in  2  requested image code
- image_req_valid  in  1  request valid
- image_req_ready  out  1  scheduler can accept a request
- row_sel  out  3  active matrix row
- row_en  out  1  row drive enable
- image_sel  out  2  image currently shown
- frame_start  out  1  one-cycle pulse at row 0 start
- digit_sel  out  2  active 7-segment digit

Behaviour:
- Interface: one clock, `clock`; `reset` is synchronous and active-high. The polarity and synchronicity of `reset` are fixed.
- Reset values: row_sel=0, row_en=0, image_sel=0, frame_start=0, digit_sel=0, image_req_ready=1. Internally, state=IDLE, and pre_cnt, pending, frame_cnt and blink_phase are all 0.
- All outputs are registered.
- State machine with three states: IDLE, BLANK, DRIVE. row_en = (state==DRIVE) && !blink_phase.
- IDLE:
  - pre_cnt=0 and row_sel=0.
  - When enable=1: go to BLANK on the next edge, and pulse frame_start in that first BLANK cycle.
- pre_cnt runs 0..ROW_DIV-1 and wraps while in BLANK or DRIVE.
- BLANK to DRIVE: on the edge where pre_cnt moves from BLANK_CYC-1 to BLANK_CYC.
- DRIVE to BLANK: on the edge where pre_cnt moves from ROW_DIV-2 to ROW_DIV-1. This gives one blank cycle before the row changes.
- Row wrap (pre_cnt ROW_DIV-1 to 0): row_sel increments, and ROWS-1 wraps to 0. When the new row is 0, frame_start=1 for that cycle. This is the frame boundary.
- enable=0 in any state: IDLE on the next edge, row_en=0, row_sel=0, pre_cnt=0. image_sel and pending are retained.
- Image request handshake:
  - Accept when valid && ready; the request is captured into pending and ready drops on the next edge.
  - At a frame boundary with pending set: image_sel<=pending, pending clears, and ready returns to 1 on the following edge.
  - In IDLE: an accepted request is applied on the next edge and ready stays 1.
  - A request accepted in the boundary cycle itself is applied at the next boundary.
  - image_req is ignored while ready=0.
- Blink:
  - When blink=1, frame_cnt counts frame boundaries. At BLINK_FRAMES it wraps to 0 and toggles blink_phase.
  - blink=0 clears frame_cnt and blink_phase on the next edge.
  - blink_phase gates row_en only; timing is unaffected.
- Digit scan:
  - When enable=1, a dig_cnt counter runs 0..DIGIT_DIV-1. On wrap, digit_sel advances and DIGITS-1 wraps to 0.
  - When enable=0, dig_cnt=0 and digit_sel=0.
- Widths: pre_cnt is $clog2(ROW_DIV) bits and dig_cnt is $clog2(DIGIT_DIV) bits. Counters never exceed their modulus.

Decomposition:
- Shared package rega_pkg holds:
  - the scan_state_t enum (IDLE, BLANK, DRIVE);
  - the image codes IMG_OFF=0, IMG_WATERING=1, IMG_DRY=2, IMG_ALARM=3;
  - the defaults CLK_HZ=50_000_000, ROW_DIV_DEFAULT and DIGIT_DIV_DEFAULT.
- One sub-module, mod_counter (parameter MOD; ports en, clr, count, wrap), instantiated for pre_cnt, dig_cnt and frame_cnt.

Test Plan (ROW_DIV=16, BLANK_CYC=2, ROWS=7, BLINK_FRAMES=2, DIGIT_DIV=8, DIGITS=4):
- Reset 3 cycles, then enable=1: frame_start pulses 1 cycle after enable. row_en is low for 2 cycles, high for 13, low for 1. row_sel goes 0,1,…,6,0 every 16 cycles. frame_start repeats every 112 cycles.
- In IDLE, image_req=2 with valid for 1 cycle, then enable: image_sel=2 one cycle after the accept, and ready stays 1.
- While scanning, image_req=3 with valid at row 3: ready=0 from the next cycle. image_sel changes to 3 exactly in the frame_start cycle, and ready=1 on the cycle after.
- blink=1 while scanning: row_en is forced 0 for frames 2–3, normal for frames 4–5, and so on. Dropping blink restores row_en within 1 cycle.
- enable=0 mid-DRIVE at row 4: next cycle row_en=0, row_sel=0, digit_sel=0. Re-enabling restarts at row 0 with a frame_start pulse.
- Free-run check: digit_sel cycles 0,1,2,3,0 every 8 cycles. Reset asserted mid-frame returns all outputs to reset values on the next edge, with ready=1.

Source files
------------

// File: rtl/rega_pkg.sv
// Shared types and constants for the irrigation display path.
// Holds the scan state encoding, the matrix image codes and the clock-derived default dividers.
package rega_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } scan_state_t;

  localparam logic [1:0] IMG_OFF      = 2'd0;
  localparam logic [1:0] IMG_WATERING = 2'd1;
  localparam logic [1:0] IMG_DRY      = 2'd2;
  localparam logic [1:0] IMG_ALARM    = 2'd3;

  localparam int CLK_HZ            = 50_000_000;
  localparam int ROW_DIV_DEFAULT   = 65536;
  localparam int DIGIT_DIV_DEFAULT = 65536;

endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD up counter with a synchronous clear; wrap is high in the cycle that rolls MOD-1 back to 0.
// Counts only when enabled; clr has priority over en.
module mod_counter
  import rega_pkg::*;
#(
  parameter int MOD = 2,
  parameter int W   = (MOD > 1) ? $clog2(MOD) : 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign wrap  = en && !clr && (count_q == LAST);

endmodule

// File: rtl/matrix_scan_scheduler.sv
// Clock-enable row/digit scan scheduler: blanked row slots, frame-aligned image swaps, blink gating.
// All outputs registered (one cycle after the deciding edge); image requests are held off via ready until the next frame boundary.
module matrix_scan_scheduler
  import rega_pkg::*;
#(
  parameter int ROW_DIV      = ROW_DIV_DEFAULT,
  parameter int BLANK_CYC    = 64,
  parameter int ROWS         = 7,
  parameter int BLINK_FRAMES = 64,
  parameter int DIGIT_DIV    = DIGIT_DIV_DEFAULT,
  parameter int DIGITS       = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       blink,
  input  logic [1:0] image_req,
  input  logic       image_req_valid,
  output logic       image_req_ready,
  output logic [2:0] row_sel,
  output logic       row_en,
  output logic [1:0] image_sel,
  output logic       frame_start,
  output logic [1:0] digit_sel
);

  localparam int PW = (ROW_DIV > 1) ? $clog2(ROW_DIV) : 1;
  localparam int DW = (DIGIT_DIV > 1) ? $clog2(DIGIT_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PW-1:0] BLANK_LAST = PW'(BLANK_CYC - 1);
  localparam logic [PW-1:0] DRIVE_LAST = PW'(ROW_DIV - 2);
  localparam logic [2:0]    ROW_LAST   = 3'(ROWS - 1);
  localparam logic [1:0]    DIG_LAST   = 2'(DIGITS - 1);

  scan_state_t state_q, state_d;
  logic [2:0]  row_sel_q, row_sel_d;
  logic        row_en_q, row_en_d;
  logic [1:0]  image_sel_q, image_sel_d;
  logic        frame_start_q, frame_start_d;
  logic [1:0]  digit_sel_q, digit_sel_d;
  logic        ready_q, ready_d;
  logic [1:0]  pend_q, pend_d;
  logic        pend_vld_q, pend_vld_d;
  logic        blink_phase_q, blink_phase_d;

  logic [PW-1:0] pre_cnt;
  logic [DW-1:0] dig_cnt;
  logic [FW-1:0] frame_cnt;
  logic          pre_wrap, dig_wrap, frame_wrap;
  logic          scanning, boundary, accept;
  logic          cnt_unused;

  assign scanning = (state_q != IDLE);
  // Leaving IDLE starts a frame just like a row-(ROWS-1) wrap does.
  assign boundary = enable && (!scanning || (pre_wrap && row_sel_q == ROW_LAST));
  assign accept   = image_req_valid && ready_q;

  mod_counter #(.MOD(ROW_DIV), .W(PW)) u_pre_cnt (
    .clock (clock),
    .reset (reset),
    .en    (enable && scanning),
    .clr   (!enable || !scanning),
    .count (pre_cnt),
    .wrap  (pre_wrap)
  );

  mod_counter #(.MOD(DIGIT_DIV), .W(DW)) u_dig_cnt (
    .clock (clock),
    .reset (reset),
    .en    (enable),
    .clr   (!enable),
    .count (dig_cnt),
    .wrap  (dig_wrap)
  );

  mod_counter #(.MOD(BLINK_FRAMES), .W(FW)) u_frame_cnt (
    .clock (clock),
    .reset (reset),
    .en    (blink && boundary),
    .clr   (!blink),
    .count (frame_cnt),
    .wrap  (frame_wrap)
  );

  assign cnt_unused = ^{dig_cnt, frame_cnt};

  always_comb begin
    state_d   = state_q;
    row_sel_d = row_sel_q;
    if (!enable) begin
      state_d   = IDLE;
      row_sel_d = '0;
    end else begin
      case (state_q)
        IDLE:    state_d = BLANK;
        BLANK:   if (pre_cnt == BLANK_LAST) state_d = DRIVE;
        DRIVE:   if (pre_cnt == DRIVE_LAST) state_d = BLANK;
        default: state_d = IDLE;
      endcase
      if (pre_wrap) begin
        row_sel_d = (row_sel_q == ROW_LAST) ? 3'd0 : row_sel_q + 3'd1;
      end
    end
  end

  always_comb begin
    blink_phase_d = blink_phase_q;
    if (!blink) begin
      blink_phase_d = 1'b0;
    end else if (frame_wrap) begin
      blink_phase_d = !blink_phase_q;
    end
    row_en_d      = (state_d == DRIVE) && !blink_phase_d;
    frame_start_d = boundary;
  end

  always_comb begin
    digit_sel_d = digit_sel_q;
    if (!enable) begin
      digit_sel_d = '0;
    end else if (dig_wrap) begin
      digit_sel_d = (digit_sel_q == DIG_LAST) ? 2'd0 : digit_sel_q + 2'd1;
    end
  end

  // A held request keeps ready low through the boundary edge that applies it.
  always_comb begin
    image_sel_d = image_sel_q;
    pend_d      = pend_q;
    pend_vld_d  = pend_vld_q;
    if (boundary && pend_vld_q) begin
      image_sel_d = pend_q;
      pend_d      = '0;
      pend_vld_d  = 1'b0;
    end
    if (accept) begin
      if (!scanning) begin
        image_sel_d = image_req;
      end else begin
        pend_d     = image_req;
        pend_vld_d = 1'b1;
      end
    end
    ready_d = !pend_vld_q && !(accept && scanning);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      row_sel_q     <= '0;
      row_en_q      <= 1'b0;
      image_sel_q   <= IMG_OFF;
      frame_start_q <= 1'b0;
      digit_sel_q   <= '0;
      ready_q       <= 1'b1;
      pend_q        <= '0;
      pend_vld_q    <= 1'b0;
      blink_phase_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      row_sel_q     <= row_sel_d;
      row_en_q      <= row_en_d;
      image_sel_q   <= image_sel_d;
      frame_start_q <= frame_start_d;
      digit_sel_q   <= digit_sel_d;
      ready_q       <= ready_d;
      pend_q        <= pend_d;
      pend_vld_q    <= pend_vld_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  assign image_req_ready = ready_q;
  assign row_sel         = row_sel_q;
  assign row_en          = row_en_q;
  assign image_sel       = image_sel_q;
  assign frame_start     = frame_start_q;
  assign digit_sel       = digit_sel_q;

endmodule

// File: tb/tb_matrix_scan_scheduler.sv
// Directed bench for matrix_scan_scheduler with small dividers (16-cycle rows, 8-cycle digits).
// Scan outputs are checked every cycle against closed-form expectations; handshake/blink/enable events at fixed cycles.
module tb_matrix_scan_scheduler;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic       blink;
  logic [1:0] image_req;
  logic       image_req_valid;
  logic       image_req_ready;
  logic [2:0] row_sel;
  logic       row_en;
  logic [1:0] image_sel;
  logic       frame_start;
  logic [1:0] digit_sel;

  int n_checks = 0;
  int n_errors = 0;
  int t;
  int bf;

  always #5 clock = ~clock;

  matrix_scan_scheduler #(
    .ROW_DIV      (16),
    .BLANK_CYC    (2),
    .ROWS         (7),
    .BLINK_FRAMES (2),
    .DIGIT_DIV    (8),
    .DIGITS       (4)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .enable          (enable),
    .blink           (blink),
    .image_req       (image_req),
    .image_req_valid (image_req_valid),
    .image_req_ready (image_req_ready),
    .row_sel         (row_sel),
    .row_en          (row_en),
    .image_sel       (image_sel),
    .frame_start     (frame_start),
    .digit_sel       (digit_sel)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0d, time %0t)", tag, got, exp, t, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // t counts cycles since the edge that left IDLE; frame f starts at t = 112*f.
  task automatic check_scan();
    int pre, frame, exp_en;
    pre    = t % 16;
    frame  = t / 112;
    exp_en = (pre >= 2 && pre <= 14) ? 1 : 0;
    if (bf >= 0 && frame >= bf + 2 && ((frame - bf - 2) / 2) % 2 == 0) exp_en = 0;
    check("row_sel",     32'(row_sel),     32'((t / 16) % 7));
    check("row_en",      32'(row_en),      32'(exp_en));
    check("frame_start", 32'(frame_start), 32'((t % 112 == 0) ? 1 : 0));
    check("digit_sel",   32'(digit_sel),   32'(((t + 1) / 8) % 4));
  endtask

  task automatic step();
    tick();
    t++;
    check_scan();
  endtask

  task automatic step_to(input int target);
    while (t < target) step();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_row_sel"},     32'(row_sel),         32'd0);
    check({tag, "_row_en"},      32'(row_en),          32'd0);
    check({tag, "_image_sel"},   32'(image_sel),       32'd0);
    check({tag, "_frame_start"}, 32'(frame_start),     32'd0);
    check({tag, "_digit_sel"},   32'(digit_sel),       32'd0);
    check({tag, "_ready"},       32'(image_req_ready), 32'd1);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; blink = 1'b0;
    image_req = 2'd0; image_req_valid = 1'b0;
    t = 0; bf = -1;
    repeat (3) tick();
    check_reset_values("rst");

    // Request while idle is applied on the next edge, ready never drops.
    reset = 1'b0; image_req = 2'd2; image_req_valid = 1'b1;
    tick();
    image_req_valid = 1'b0; image_req = 2'd0;
    check("idle_img", 32'(image_sel), 32'd2);
    check("idle_rdy", 32'(image_req_ready), 32'd1);
    check("idle_row_en", 32'(row_en), 32'd0);

    enable = 1'b1;
    tick();
    t = 0;
    check_scan();
    check("start_img", 32'(image_sel), 32'd2);

    // Request at row 3 of frame 2 waits for the frame 3 boundary.
    step_to(272);
    image_req = 2'd3; image_req_valid = 1'b1;
    step();
    image_req_valid = 1'b0; image_req = 2'd0;
    check("req_rdy_low", 32'(image_req_ready), 32'd0);
    check("req_img_hold", 32'(image_sel), 32'd2);

    step_to(300);
    image_req = 2'd1; image_req_valid = 1'b1;
    step();
    image_req_valid = 1'b0; image_req = 2'd0;

    step_to(335);
    check("pre_bnd_img", 32'(image_sel), 32'd2);
    check("pre_bnd_rdy", 32'(image_req_ready), 32'd0);
    step();
    check("bnd_img", 32'(image_sel), 32'd3);
    check("bnd_rdy", 32'(image_req_ready), 32'd0);

    // Blink raised during frame 3: frames 5-6 dark, 7-8 lit, 9 dark.
    blink = 1'b1; bf = 3;
    step();
    check("post_bnd_rdy", 32'(image_req_ready), 32'd1);
    step_to(448);
    check("ignored_req_img", 32'(image_sel), 32'd3);

    step_to(1028);
    blink = 1'b0; bf = -1;
    step();

    step_to(1077);
    check("pre_dis_row_en", 32'(row_en), 32'd1);
    enable = 1'b0;
    tick();
    check("dis_row_en",      32'(row_en),          32'd0);
    check("dis_row_sel",     32'(row_sel),         32'd0);
    check("dis_digit_sel",   32'(digit_sel),       32'd0);
    check("dis_frame_start", 32'(frame_start),     32'd0);
    check("dis_img_kept",    32'(image_sel),       32'd3);
    check("dis_rdy",         32'(image_req_ready), 32'd1);
    tick(); tick();
    check("idle_row_sel",     32'(row_sel),     32'd0);
    check("idle_frame_start", 32'(frame_start), 32'd0);
    check("idle_digit_sel",   32'(digit_sel),   32'd0);

    enable = 1'b1;
    tick();
    t = 0;
    check_scan();

    // Accepted on the boundary edge itself: applied one frame later.
    step_to(111);
    image_req = 2'd1; image_req_valid = 1'b1;
    step();
    image_req_valid = 1'b0; image_req = 2'd0;
    check("bacc_rdy", 32'(image_req_ready), 32'd0);
    check("bacc_img", 32'(image_sel), 32'd3);
    step_to(223);
    check("bacc_pre_img", 32'(image_sel), 32'd3);
    step();
    check("bacc_img_applied", 32'(image_sel), 32'd1);
    check("bacc_rdy_bnd", 32'(image_req_ready), 32'd0);
    step();
    check("bacc_rdy_back", 32'(image_req_ready), 32'd1);

    step_to(250);
    reset = 1'b1;
    tick();
    check_reset_values("midrst");
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
